// File: rtl/hex_count_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_count_pkg
// Purpose  : Shared definitions for the hex count source. Holds the step-period
//            speed codes and the reload-value helper used by the top level.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hex_count_pkg;

  typedef enum logic [1:0] {
    SPD_FAST = 2'b00,
    SPD_1S   = 2'b01,
    SPD_2S   = 2'b10,
    SPD_4S   = 2'b11
  } speed_e;

  // Divider reload value R for a speed code. The counter steps once every
  // R+1 enabled cycles, so R = 0 gives a step on every enabled cycle.
  function automatic logic [31:0] reload(input logic [1:0] spd,
                                         input int unsigned clk_hz);
    logic [31:0] r;
    r = 32'd0;
    case (spd)
      SPD_FAST: r = 32'd0;
      SPD_1S:   r = 32'(clk_hz - 1);
      SPD_2S:   r = 32'((2 * clk_hz) - 1);
      SPD_4S:   r = 32'((4 * clk_hz) - 1);
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_count_source_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_count_source_if
// Purpose  : Control/data bundle between the hex count source and its user.
//            master drives the controls and reads count/tick; slave is the
//            counter itself.
// Signals  : enable, load, load_value[3:0], speed[1:0], up_down (to source)
//            count[3:0], tick (from source)
//            seg[6:0] (from source, only with HEX_COUNT_SOURCE_SEG_EN)
// Revision : 1.0 - initial release
// ============================================================================
interface hex_count_source_if;

  logic       enable;
  logic       load;
  logic [3:0] load_value;
  logic [1:0] speed;
  logic       up_down;
  logic [3:0] count;
  logic       tick;
`ifdef HEX_COUNT_SOURCE_SEG_EN
  logic [6:0] seg;

  modport master (
    output enable, load, load_value, speed, up_down,
    input  count, tick, seg
  );

  modport slave (
    input  enable, load, load_value, speed, up_down,
    output count, tick, seg
  );
`else
  modport master (
    output enable, load, load_value, speed, up_down,
    input  count, tick
  );

  modport slave (
    input  enable, load, load_value, speed, up_down,
    output count, tick
  );
`endif

endinterface
`default_nettype wire

// File: rtl/hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hex_decoder
// Purpose  : Combinational 4-bit to 7-segment decoder, active-high segments.
// Ports    : hex[3:0] - nibble in
//            seg[6:0] - segments, bit 0 = a ... bit 6 = g
// Revision : 1.0 - initial release
// ============================================================================
module hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (hex)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rate_divider.sv
`default_nettype none
// ============================================================================
// Module   : rate_divider
// Purpose  : Down-counting period divider. Emits a combinational step pulse in
//            the enabled cycle where the divider sits at zero, then reloads.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            enable         - 1 = count down, 0 = hold
//            restart        - reload the divider, suppress any step
//            reload[DIV_W]  - value loaded on reset/restart/step
//            step           - one-cycle step request to the counter
// Revision : 1.0 - initial release
// ============================================================================
module rate_divider #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [DIV_W-1:0] reload,
  output logic             step
);

  localparam logic [DIV_W-1:0] C_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_div;
  logic             w_zero;

  assign w_zero = (r_div == '0);
  // A restart wins over a pending step, so no tick survives a reload.
  assign step   = enable && !restart && w_zero;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_div <= reload;
    end else if (enable) begin
      if (w_zero) begin
        r_div <= reload;
      end else begin
        r_div <= r_div - C_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hex_count_source.sv
`default_nettype none
// ============================================================================
// Module   : hex_count_source
// Purpose  : Nibble source for the 7-segment hex digit path. Steps a 4-bit
//            up/down counter once per programmable period, with parallel load
//            and enable/hold. Priority: reset > load > speed change > step.
// Ports    : clk   - board clock
//            reset - synchronous, active-high reset
//            bus   - hex_count_source_if.slave (enable, load, load_value,
//                    speed, up_down in; count, tick [, seg] out)
// Options  : HEX_COUNT_SOURCE_SEG_EN - adds bus.seg, driven by a hex_decoder
//            on count (combinational, same cycle as count).
// Params   : CLK_HZ - clock cycles per second
//            DIV_W  - divider width, must hold 4*CLK_HZ-1
// Revision : 1.0 - initial release
// ============================================================================
module hex_count_source #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIV_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  hex_count_source_if.slave bus
);

  import hex_count_pkg::*;

  logic [DIV_W-1:0] w_reload;
  logic             w_speed_chg;
  logic             w_restart;
  logic             w_step;
  logic [1:0]       r_speed_q;
  logic [3:0]       r_count;
  logic             r_tick;

  assign w_reload    = DIV_W'(reload(bus.speed, CLK_HZ));
  assign w_speed_chg = (bus.speed != r_speed_q);
  // Load and speed change both restart the period, regardless of enable.
  assign w_restart   = bus.load || w_speed_chg;

  rate_divider #(
    .DIV_W (DIV_W)
  ) u_rate_divider (
    .clk     (clk),
    .reset   (reset),
    .enable  (bus.enable),
    .restart (w_restart),
    .reload  (w_reload),
    .step    (w_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= 4'h0;
      r_tick    <= 1'b0;
      r_speed_q <= bus.speed;
    end else begin
      r_speed_q <= bus.speed;
      r_tick    <= 1'b0;
      if (bus.load) begin
        r_count <= bus.load_value;
      end else if (w_step) begin
        // Modulo-16 wrap falls out of the 4-bit arithmetic.
        r_count <= bus.up_down ? (r_count + 4'd1) : (r_count - 4'd1);
        r_tick  <= 1'b1;
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tick  = r_tick;

`ifdef HEX_COUNT_SOURCE_SEG_EN
  logic [6:0] w_seg;

  hex_decoder u_hex_decoder (
    .hex (r_count),
    .seg (w_seg)
  );

  assign bus.seg = w_seg;
`endif

endmodule
`default_nettype wire

// File: doc/hex_count_source.md
Name: hex_count_source

Overview:
- Upstream nibble source for the board's 7-segment hex digit path.
- Produces a 4-bit value that steps once per programmable period derived from the board clock.
- Supports up/down counting, parallel load from switches, and enable/hold.
- count drives the hex decoder's 4-bit input directly.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per second. Benches use a small value, e.g. 4.
- DIV_W, 32, divider register width. Must hold 4*CLK_HZ-1.

Ports:
- clk  in  1  board clock (50 MHz on board).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = divider and counter run; 0 = both hold.
- load  in  1  1 = load load_value into count this edge.
- load_value  in  4  value to load.
- speed  in  2  step period select: 00 = every cycle, 01 = 1 s, 10 = 2 s, 11 = 4 s.
- up_down  in  1  1 = increment, 0 = decrement.
- count  out  4  current value; feeds the hex decoder.
- tick  out  1  one-cycle pulse, high in the cycle count shows a newly stepped value.

Behaviour:
- One clock domain. All state updates on the rising edge of clk.
- Reload value R(speed):
  - 00 → 0
  - 01 → CLK_HZ-1
  - 10 → 2*CLK_HZ-1
  - 11 → 4*CLK_HZ-1
- Reset (synchronous, active-high):
  - count = 0, tick = 0, divider = R(speed).
  - speed_q = speed, where speed_q is the registered copy of speed.
- Priority per edge, highest first: reset > load > speed change > enable step.
- Load:
  - count = load_value, divider = R(speed), tick = 0.
  - Ignores enable.
- Speed change (speed != speed_q, no load):
  - divider = R(speed), count holds, tick = 0.
  - speed_q updates every edge.
- enable = 0: divider, count and speed_q tracking as above; tick = 0.
- enable = 1, divider != 0: divider decrements by 1; tick = 0.
- enable = 1, divider == 0:
  - divider = R(speed).
  - count = count+1 if up_down = 1, else count-1, modulo 16.
  - tick = 1.
- Wrap-around: F+1 → 0 and 0-1 → F. No saturation, no flag.
- Step period:
  - Exactly R+1 enabled cycles between ticks.
  - speed 00 steps every enabled cycle, so tick stays high continuously.
- Latency:
  - Load visible on count the cycle after the edge.
  - First tick after reset/load/speed change comes after R+1 enabled cycles.
- Reset mid-count: divider progress is discarded; no pending tick survives.
- up_down change takes effect at the next step. The divider is not restarted.

Optional Feature:
- Macro: HEX_COUNT_SOURCE_SEG_EN.
- Defined:
  - Adds output seg (out, 7 bits), active-high segments, bit 0 = a … bit 6 = g.
  - seg is driven by an instance of the existing hex decoder on count.
  - Purely combinational from count, so seg changes in the same cycle as count.
- Undefined: no seg port, no decoder instance; count is the only data output.

Decomposition:
- Shared package hex_count_pkg:
  - speed codes SPD_FAST = 2'b00, SPD_1S = 2'b01, SPD_2S = 2'b10, SPD_4S = 2'b11.
  - Function reload(speed, CLK_HZ) returning R.
- One natural sub-module: rate_divider.
  - Inputs: clk, reset, enable, restart, reload value.
  - Output: step pulse when the count reaches 0 while enabled.
  - The top level holds count, load/priority logic and speed_q.

Test Plan (CLK_HZ = 4):
- reset high 2 cycles, then enable = 1, speed = 01, up_down = 1 → count 0 for 4 cycles; tick on cycle 4 with count = 1; count = 2 on cycle 8.
- load = 1, load_value = E, then up counting at speed 00 → count E, F, 0, 1 on consecutive cycles; tick high each cycle.
- up_down = 0 from count 1, speed 00 → count 0, F, E.
- enable dropped for 10 cycles mid-period at divider = 2 → count and tick frozen; on re-enable, the next tick comes 3 cycles later.
- speed switched 01 → 11 with divider = 1 → no tick on the next cycle; next tick 16 enabled cycles after the switch edge.
- load and reset asserted on the same edge → count = 0, tick = 0. With HEX_COUNT_SOURCE_SEG_EN defined: count = 0 gives seg = 7'b0111111; count = 8 gives seg = 7'b1111111.
